// File: rtl/coin_pulser_if.sv
// -----------------------------------------------------------------------------
// coin_pulser_if
//
// Purpose : groups the coin pulser's frame reference, raw coin requests and
//           shaped outputs into one bundle. Clock and reset stay plain ports.
//
// Signals :
//   strobe    1        frame reference (vsync); a rising edge is a frame tick
//   btn_in    CHANNELS raw active-high coin requests (clk domain)
//   coin_out  CHANNELS active-high shaped coin pulses
//   busy      CHANNELS channel active or coins still queued
//
// Modports:
//   master : drives strobe/btn_in, observes coin_out/busy (stimulus side)
//   slave  : the coin_pulser itself
// -----------------------------------------------------------------------------
interface coin_pulser_if #(
  parameter int CHANNELS = 2
);
  logic                strobe;
  logic [CHANNELS-1:0] btn_in;
  logic [CHANNELS-1:0] coin_out;
  logic [CHANNELS-1:0] busy;

  modport master (
    output strobe,
    output btn_in,
    input  coin_out,
    input  busy
  );

  modport slave (
    input  strobe,
    input  btn_in,
    output coin_out,
    output busy
  );
endinterface

// File: rtl/coin_pulser.sv
// -----------------------------------------------------------------------------
// coin_pulser
//
// Purpose : conditions raw coin requests for the game CPU. Each channel
//           debounces its request, counts insertions in a saturating queue and
//           replays every queued coin as a pulse that is exactly PULSE_FRAMES
//           frame ticks wide, followed by a low gap of exactly GAP_FRAMES
//           ticks before the next queued coin. Channels are independent and
//           share only the frame tick.
//
// Ports   :
//   clk    in  1          system clock
//   reset  in  1          synchronous, active-high
//   bus    coin_pulser_if.slave
//            strobe   in  frame reference, rising edge = tick
//            btn_in   in  raw coin requests, one bit per channel
//            coin_out out shaped coin pulses, one bit per channel
//            busy     out channel not idle or coins pending
//
// Build option:
//   COIN_PULSER_DEBOUNCE_EN  when defined, each request must be stable for
//                            DB_CYCLES clocks before it is believed. When not
//                            defined the request is simply registered once and
//                            DB_CYCLES is ignored.
//
// Note: the interface instance must be built with the same CHANNELS value.
// -----------------------------------------------------------------------------
module coin_pulser #(
  parameter int CHANNELS     = 2,
  parameter int DB_CYCLES    = 16,
  parameter int PULSE_FRAMES = 3,
  parameter int GAP_FRAMES   = 3,
  parameter int QUEUE_MAX    = 7
) (
  input  logic         clk,
  input  logic         reset,
  coin_pulser_if.slave bus
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter range checks
  // ---------------------------------------------------------------------------
  if (CHANNELS < 1) begin : g_bad_channels
    $error("coin_pulser: CHANNELS must be at least 1");
  end
  if (DB_CYCLES < 1 || DB_CYCLES > 65535) begin : g_bad_db_cycles
    $error("coin_pulser: DB_CYCLES must be in 1..65535");
  end
  if (PULSE_FRAMES < 1 || PULSE_FRAMES > 15) begin : g_bad_pulse_frames
    $error("coin_pulser: PULSE_FRAMES must be in 1..15");
  end
  if (GAP_FRAMES < 1 || GAP_FRAMES > 15) begin : g_bad_gap_frames
    $error("coin_pulser: GAP_FRAMES must be in 1..15");
  end
  if (QUEUE_MAX < 1 || QUEUE_MAX > 255) begin : g_bad_queue_max
    $error("coin_pulser: QUEUE_MAX must be in 1..255");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int QW = $clog2(QUEUE_MAX + 1);
  localparam logic [QW-1:0] Q_FULL = QW'(QUEUE_MAX);

  // "fc + 1 == FRAMES" is checked as "fc == FRAMES - 1" so the 4-bit
  // counter never has to represent 16.
  localparam logic [3:0] FC_PULSE_LAST = 4'(PULSE_FRAMES - 1);
  localparam logic [3:0] FC_GAP_LAST   = 4'(GAP_FRAMES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // Frame tick, shared by every channel
  // ---------------------------------------------------------------------------
  logic strobe_d_reg;
  logic tick;

  always_ff @(posedge clk) begin
    if (reset) begin
      strobe_d_reg <= 1'b0;
    end else begin
      strobe_d_reg <= bus.strobe;
    end
  end

  // strobe_d resets low, so a strobe already high when reset releases gives
  // one tick in the first cycle afterwards; a strobe held high gives only one.
  assign tick = bus.strobe & ~strobe_d_reg;

  // ---------------------------------------------------------------------------
  // Per-channel logic
  // ---------------------------------------------------------------------------
  logic [CHANNELS-1:0] coin_vec;
  logic [CHANNELS-1:0] busy_vec;

  genvar gi;
  for (gi = 0; gi < CHANNELS; gi++) begin : g_ch

    logic db_reg;      // conditioned request level
    logic db_d_reg;    // previous conditioned level, for edge detection
    logic rise;        // one-cycle insertion request

`ifdef COIN_PULSER_DEBOUNCE_EN
    // The level only follows btn_in after DB_CYCLES consecutive samples that
    // disagree with it; any agreeing sample restarts the count.
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    logic [DBW-1:0] db_cnt_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        db_reg     <= 1'b0;
        db_cnt_reg <= '0;
      end else if (bus.btn_in[gi] != db_reg) begin
        if (db_cnt_reg == DB_LAST) begin
          db_reg     <= bus.btn_in[gi];
          db_cnt_reg <= '0;
        end else begin
          db_cnt_reg <= db_cnt_reg + 1'b1;
        end
      end else begin
        db_cnt_reg <= '0;
      end
    end
`else
    // No filtering: one register stage, so a single-cycle high still counts.
    always_ff @(posedge clk) begin
      if (reset) begin
        db_reg <= 1'b0;
      end else begin
        db_reg <= bus.btn_in[gi];
      end
    end
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        db_d_reg <= 1'b0;
      end else begin
        db_d_reg <= db_reg;
      end
    end

    // db_d resets low, so a button held through reset becomes a fresh
    // insertion once the conditioned level rises again.
    assign rise = db_reg & ~db_d_reg;

    // -------------------------------------------------------------------------
    // Pulse FSM, pending-coin queue and registered outputs
    // -------------------------------------------------------------------------
    state_t        state_reg, state_next;
    logic [3:0]    fc_reg, fc_next;
    logic [QW-1:0] q_reg, q_next;
    logic          coin_reg, coin_next;
    logic          busy_reg, busy_next;
    logic          take;   // FSM consumes one queued coin this cycle

    always_ff @(posedge clk) begin
      if (reset) begin
        state_reg <= ST_IDLE;
        fc_reg    <= '0;
        q_reg     <= '0;
        coin_reg  <= 1'b0;
        busy_reg  <= 1'b0;
      end else begin
        state_reg <= state_next;
        fc_reg    <= fc_next;
        q_reg     <= q_next;
        coin_reg  <= coin_next;
        busy_reg  <= busy_next;
      end
    end

    always_comb begin
      state_next = state_reg;
      fc_next    = fc_reg;
      take       = 1'b0;

      case (state_reg)
        ST_IDLE: begin
          if (tick && (q_reg != '0)) begin
            state_next = ST_PULSE;
            fc_next    = '0;
            take       = 1'b1;
          end
        end

        ST_PULSE: begin
          if (tick) begin
            if (fc_reg == FC_PULSE_LAST) begin
              state_next = ST_GAP;
              fc_next    = '0;
            end else begin
              fc_next = fc_reg + 4'd1;
            end
          end
        end

        ST_GAP: begin
          if (tick) begin
            if (fc_reg == FC_GAP_LAST) begin
              fc_next = '0;
              // Back-to-back coins skip IDLE so the gap is exact.
              if (q_reg != '0) begin
                state_next = ST_PULSE;
                take       = 1'b1;
              end else begin
                state_next = ST_IDLE;
              end
            end else begin
              fc_next = fc_reg + 4'd1;
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
          fc_next    = '0;
        end
      endcase

      // Queue: an insertion and a consumption in the same cycle cancel, which
      // keeps the new coin even when the count is already at its ceiling.
      q_next = q_reg;
      if (rise && !take) begin
        if (q_reg != Q_FULL) begin
          q_next = q_reg + 1'b1;
        end
      end else if (!rise && take) begin
        q_next = q_reg - 1'b1;
      end

      coin_next = (state_next == ST_PULSE);
      busy_next = (state_next != ST_IDLE) || (q_next != '0);
    end

    assign coin_vec[gi] = coin_reg;
    assign busy_vec[gi] = busy_reg;
  end

  assign bus.coin_out = coin_vec;
  assign bus.busy     = busy_vec;

endmodule

// File: tb/tb_coin_pulser.sv
// -----------------------------------------------------------------------------
// tb_coin_pulser
//
// Randomised bench for coin_pulser. Every clean insertion is turned into an
// expected pulse (rise cycle, fall cycle) by a schedule model that works in
// frame-tick arithmetic; a separate monitor compares every observed pulse and
// every change of busy against that schedule.
// -----------------------------------------------------------------------------
module tb_coin_pulser;

  localparam int CH   = 2;
  localparam int DB   = 16;
  localparam int PF   = 3;
  localparam int GF   = 3;
  localparam int QM   = 7;
  localparam int TOFF = 40;

`ifdef COIN_PULSER_DEBOUNCE_EN
  localparam int LAT  = DB + 1;   // btn rise in cycle t -> queue counts it in t+LAT
  localparam int TPER = 500;
  localparam bit DEB  = 1'b1;
`else
  localparam int LAT  = 2;
  localparam int TPER = 150;
  localparam bit DEB  = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  coin_pulser_if #(.CHANNELS(CH)) bus ();

  coin_pulser #(
    .CHANNELS    (CH),
    .DB_CYCLES   (DB),
    .PULSE_FRAMES(PF),
    .GAP_FRAMES  (GF),
    .QUEUE_MAX   (QM)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int sw    = 1;
  int dropped = 0;

  typedef struct {
    int rise;
    int fall;
  } exp_t;

  exp_t sb_q   [CH][$];
  int   sched  [CH][$];
  int   bz_beg [CH][$];
  int   bz_end [CH][$];
  int   last_start[CH];
  int   busy_last [CH];
  int   rises     [CH];
  int   in_pulse  [CH];
  int   exp_fall  [CH];
  int   rise_at   [CH];
  logic prev_coin [CH];
  logic prev_busy [CH];
  logic prev_bexp [CH];
  logic rst_prev = 1'b1;

  // Frame tick k happens in cycle TOFF + k*TPER.
  function automatic int tick_cyc(input int k);
    return TOFF + k * TPER;
  endfunction

  function automatic int first_tick(input int r);
    if (r <= TOFF) return 0;
    return (r - TOFF + TPER - 1) / TPER;
  endfunction

  function automatic bit near_tick(input int r);
    return tick_cyc(first_tick(r - 3)) <= r + 3;
  endfunction

  task automatic chk(input string name, input int ch, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s ch%0d @cycle %0d: got %0d, expected %0d", name, ch, cyc, got, want);
    end
  endtask

  task automatic model_clear();
    for (int ch = 0; ch < CH; ch++) begin
      sb_q[ch].delete();
      sched[ch].delete();
      bz_beg[ch].delete();
      bz_end[ch].delete();
      last_start[ch] = -1000;
      busy_last[ch]  = 0;
    end
  endtask

  // A request counted by the queue in cycle r: drop it if QM coins are still
  // waiting, else it starts at the first tick it can see that is also at
  // least PF+GF ticks after the previous coin's start.
  task automatic model_request(input logic [CH-1:0] mask, input int r);
    for (int ch = 0; ch < CH; ch++) begin
      if (mask[ch]) begin
        int pend;
        int e;
        int s;
        exp_t x;
        pend = 0;
        for (int i = 0; i < sched[ch].size(); i++)
          if (tick_cyc(sched[ch][i]) > r) pend++;
        if (pend >= QM) begin
          dropped++;
          $display("request ch%0d @%0d dropped, %0d coins waiting", ch, r, pend);
        end else begin
          e = first_tick(r);
          s = (e > last_start[ch] + PF + GF) ? e : last_start[ch] + PF + GF;
          last_start[ch] = s;
          sched[ch].push_back(s);
          x.rise = tick_cyc(s) + 1;
          x.fall = tick_cyc(s + PF) + 1;
          sb_q[ch].push_back(x);
          if (bz_end[ch].size() == 0 || r > bz_end[ch][bz_end[ch].size()-1]) begin
            bz_beg[ch].push_back(r);
            bz_end[ch].push_back(tick_cyc(s + PF + GF));
          end else begin
            bz_end[ch][bz_end[ch].size()-1] = tick_cyc(s + PF + GF);
          end
          busy_last[ch] = tick_cyc(s + PF + GF);
          $display("request ch%0d @%0d -> expect pulse cycles %0d..%0d", ch, r, x.rise, x.fall - 1);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc >= TOFF && ((cyc - TOFF) % TPER) == 0) sw = $urandom_range(1, 5);
    bus.strobe = (cyc >= TOFF) && (((cyc - TOFF) % TPER) < sw);
  endtask

  task automatic press(input logic [CH-1:0] mask, input int hi, input int lo);
    step();
    while (near_tick(cyc + LAT)) step();
    model_request(mask, cyc + LAT);
    bus.btn_in = mask;
    repeat (hi) step();
    bus.btn_in = '0;
    repeat (lo) step();
  endtask

  task automatic rand_press(input logic [CH-1:0] mask);
    if (DEB) press(mask, $urandom_range(DB + 2, DB + 8), $urandom_range(DB + 2, DB + 8));
    else     press(mask, $urandom_range(1, 3), $urandom_range(1, 4));
  endtask

  task automatic idle_wait();
    int target;
    target = cyc + 3;
    for (int ch = 0; ch < CH; ch++)
      if (busy_last[ch] + 3 > target) target = busy_last[ch] + 3;
    while (cyc < target) step();
  endtask

  task automatic wait_after_tick();
    step();
    while (cyc < TOFF || ((cyc - TOFF) % TPER) != 3) step();
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops an expectation for every rising coin_out, checks the fall,
  // and checks busy whenever either the DUT or the model changes it.
  // ---------------------------------------------------------------------------
  initial begin
    for (int ch = 0; ch < CH; ch++) begin
      in_pulse[ch]  = 0;
      prev_coin[ch] = 1'b0;
      prev_busy[ch] = 1'b0;
      prev_bexp[ch] = 1'b0;
    end
    forever begin
      @(negedge clk);
      for (int ch = 0; ch < CH; ch++) begin
        logic c;
        logic b;
        logic be;
        exp_t x;
        c  = bus.coin_out[ch];
        b  = bus.busy[ch];
        be = 1'b0;
        for (int i = 0; i < bz_beg[ch].size(); i++)
          if (cyc >= bz_beg[ch][i] && cyc <= bz_end[ch][i]) be = 1'b1;
        if (reset || rst_prev) begin
          in_pulse[ch] = 0;
        end else begin
          if (c && !prev_coin[ch]) begin
            rises[ch]++;
            rise_at[ch] = cyc;
            if (sb_q[ch].size() == 0) begin
              chk("unexpected_pulse", ch, cyc, -1);
              in_pulse[ch] = 0;
            end else begin
              x = sb_q[ch].pop_front();
              chk("pulse_rise", ch, cyc, x.rise);
              exp_fall[ch] = x.fall;
              in_pulse[ch] = 1;
            end
          end
          if (!c && prev_coin[ch] && in_pulse[ch] != 0) begin
            chk("pulse_fall", ch, cyc, exp_fall[ch]);
            in_pulse[ch] = 0;
            $display("pulse ch%0d high cycles %0d..%0d", ch, rise_at[ch], cyc - 1);
          end
          if (b != prev_busy[ch] || be != prev_bexp[ch])
            chk("busy", ch, int'(b), int'(be));
        end
        prev_coin[ch] = c;
        prev_busy[ch] = b;
        prev_bexp[ch] = be;
      end
      rst_prev = reset;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int r0;
    int r1;
    int s2;
    int target;

    reset        = 1'b1;
    bus.strobe   = 1'b0;
    bus.btn_in   = '0;
    for (int ch = 0; ch < CH; ch++) rises[ch] = 0;
    model_clear();

    repeat (3) step();
    chk("reset_coin", 0, int'(bus.coin_out), 0);
    chk("reset_busy", 0, int'(bus.busy), 0);
    step();
    reset = 1'b0;
    step();
    chk("post_reset_coin", 0, int'(bus.coin_out), 0);
    chk("post_reset_busy", 0, int'(bus.busy), 0);

    // Single coin: one 40-cycle press on channel 0.
    r0 = rises[0];
    r1 = rises[1];
    press(2'b01, 40, DB + 4);
    idle_wait();
    chk("single_count", 0, rises[0] - r0, 1);
    chk("single_other", 1, rises[1] - r1, 0);

    r0 = rises[0];
    if (DEB) begin
      // Bounce: toggling every 5 cycles never survives the filter.
      for (int i = 0; i < 40; i++) begin
        bus.btn_in[0] = ~bus.btn_in[0];
        repeat (5) step();
      end
      bus.btn_in = '0;
      repeat (DB + 4) step();
      idle_wait();
      chk("bounce_count", 0, rises[0] - r0, 0);
    end else begin
      // Single-cycle highs are each one insertion.
      wait_after_tick();
      for (int i = 0; i < 3; i++) press(2'b01, 1, 3);
      idle_wait();
      chk("short_count", 0, rises[0] - r0, 3);
    end

    // Burst of five inside one frame.
    r0 = rises[0];
    wait_after_tick();
    for (int i = 0; i < 5; i++) rand_press(2'b01);
    idle_wait();
    chk("burst_count", 0, rises[0] - r0, 5);

    // Saturation: ten insertions before the first tick.
    r0 = rises[0];
    wait_after_tick();
    for (int i = 0; i < 10; i++) rand_press(2'b01);
    idle_wait();
    chk("saturate_count", 0, rises[0] - r0, QM);

    // Both channels together.
    r0 = rises[0];
    r1 = rises[1];
    rand_press(2'b11);
    idle_wait();
    chk("simul_count", 0, rises[0] - r0, 1);
    chk("simul_count", 1, rises[1] - r1, 1);

    // Reset in the middle of the second pulse of a four-coin burst.
    r0 = rises[0];
    wait_after_tick();
    for (int i = 0; i < 4; i++) rand_press(2'b01);
    s2 = sched[0][sched[0].size() - 3];
    target = tick_cyc(s2 + 1) + TPER / 2;
    while (cyc < target) step();
    reset = 1'b1;
    model_clear();
    step();
    reset = 1'b0;
    chk("midreset_coin", 0, int'(bus.coin_out[0]), 0);
    chk("midreset_busy", 0, int'(bus.busy[0]), 0);
    repeat (6 * TPER) step();
    chk("midreset_count", 0, rises[0] - r0, 2);

    // Random traffic.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, TPER)) step();
      rand_press(CH'($urandom_range(1, 3)));
    end
    idle_wait();
    repeat (5) step();

    for (int ch = 0; ch < CH; ch++) begin
      chk("leftover_pulses", ch, sb_q[ch].size(), 0);
      chk("stuck_pulse", ch, in_pulse[ch], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog @cycle %0d: got timeout, expected completion", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
